// File: rtl/tpu_host_pkg.sv
// TPU host sequencer shared types.
// Opcodes, FSM states and TPU register map.
package tpu_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'b00,
    OP_READ     = 2'b01,
    OP_POLL     = 2'b10,
    OP_WAIT_IRQ = 2'b11
  } tpu_host_op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_GAP     = 3'd2,
    S_CHECK   = 3'd3,
    S_WAITIRQ = 3'd4,
    S_RESP    = 3'd5
  } tpu_host_state_e;

  localparam logic [31:0] TPU_REG_CTRL     = 32'h00;
  localparam logic [31:0] TPU_REG_STATUS   = 32'h04;
  localparam logic [31:0] TPU_REG_CMD      = 32'h08;
  localparam logic [31:0] TPU_REG_SRC      = 32'h0C;
  localparam logic [31:0] TPU_REG_DST      = 32'h10;
  localparam logic [31:0] TPU_REG_CFG      = 32'h14;
  localparam logic [31:0] TPU_REG_RESULT   = 32'h18;
  localparam logic [31:0] TPU_REG_PERF_CNT = 32'h1C;

endpackage

// File: rtl/tpu_host_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries.
// No bypass: a pushed entry is visible to pop one cycle later.
module tpu_host_cmd_fifo
  import tpu_host_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  // Read/write pointers with wrap bit for full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/tpu_host_seq.sv
// Host command sequencer for a TPU register slave.
// Queues commands and runs them one at a time on the bus.
module tpu_host_seq
  import tpu_host_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int POLL_MAX   = 1024,
  parameter int BUS_TMO    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  bus_sel,
  output logic                  bus_wen,
  output logic                  bus_ren,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready,
  input  logic                  irq,
  output logic                  busy
);

  localparam int PW = $clog2(POLL_MAX) + 1;
  localparam int TW = $clog2(BUS_TMO) + 1;
  localparam int EW = 2 + ADDR_WIDTH + 2 * DATA_WIDTH;

  tpu_host_state_e state, nstate;

  logic [EW-1:0]         f_din;
  logic [EW-1:0]         f_dout;
  logic                  f_full;
  logic                  f_empty;
  logic                  f_push;
  logic                  pop;
  tpu_host_op_e          f_op;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [DATA_WIDTH-1:0] f_data;
  logic [DATA_WIDTH-1:0] f_mask;

  tpu_host_op_e          cur_op;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [DATA_WIDTH-1:0] cur_mask;
  logic [DATA_WIDTH-1:0] cap;
  logic [PW-1:0]         poll_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic [DATA_WIDTH-1:0] wait_cnt;

  logic                  rsp_ld;
  logic [DATA_WIDTH-1:0] rsp_d;
  logic                  rsp_e;
  logic                  ack;
  logic                  match;

  assign f_push = cmd_valid && cmd_ready;
  assign f_din  = {cmd_op, cmd_addr, cmd_data, cmd_mask};
  assign f_op   = tpu_host_op_e'(f_dout[EW-1 -: 2]);
  assign f_addr = f_dout[2*DATA_WIDTH +: ADDR_WIDTH];
  assign f_data = f_dout[DATA_WIDTH +: DATA_WIDTH];
  assign f_mask = f_dout[0 +: DATA_WIDTH];

  tpu_host_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .din   (f_din),
    .pop   (pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  // Strobes derive from state so reset drops them at once.
  assign bus_sel   = (state == S_ISSUE);
  assign bus_wen   = bus_sel && (cur_op == OP_WRITE);
  assign bus_ren   = bus_sel && (cur_op != OP_WRITE);
  assign bus_addr  = cur_addr;
  assign bus_wdata = cur_data;
  assign ack       = bus_sel && bus_ready;
  assign match     = ((cap & cur_mask) == (cur_data & cur_mask));

  assign cmd_ready = !f_full;
  assign rsp_valid = (state == S_RESP);
  assign busy      = !f_empty || (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  // Next state, FIFO pop and response load.
  always_comb begin
    nstate = state;
    pop    = 1'b0;
    rsp_ld = 1'b0;
    rsp_d  = '0;
    rsp_e  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!f_empty) begin
          pop    = 1'b1;
          nstate = (f_op == OP_WAIT_IRQ) ? S_WAITIRQ : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus_ready) begin
          nstate = S_GAP;
        end else if (tmo_cnt == TW'(BUS_TMO - 1)) begin
          nstate = S_RESP;
          rsp_ld = 1'b1;
          rsp_e  = 1'b1;
        end
      end
      S_GAP: begin
        unique case (1'b1)
          (cur_op == OP_WRITE): begin
            nstate = S_RESP;
            rsp_ld = 1'b1;
          end
          (cur_op == OP_READ): begin
            nstate = S_RESP;
            rsp_ld = 1'b1;
            rsp_d  = cap;
          end
          default: nstate = S_CHECK;
        endcase
      end
      S_CHECK: begin
        if (match) begin
          nstate = S_RESP;
          rsp_ld = 1'b1;
          rsp_d  = cap;
        end else if (poll_cnt == PW'(POLL_MAX)) begin
          nstate = S_RESP;
          rsp_ld = 1'b1;
          rsp_d  = cap;
          rsp_e  = 1'b1;
        end else begin
          nstate = S_ISSUE;
        end
      end
      S_WAITIRQ: begin
        if (irq) begin
          nstate = S_RESP;
          rsp_ld = 1'b1;
          rsp_d  = wait_cnt;
        end else if (cur_data != '0 &&
                     wait_cnt == cur_data - DATA_WIDTH'(1)) begin
          nstate = S_RESP;
          rsp_ld = 1'b1;
          rsp_d  = cur_data;
          rsp_e  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Latch the popped command for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_op   <= OP_WRITE;
      cur_addr <= '0;
      cur_data <= '0;
      cur_mask <= '0;
    end else if (pop) begin
      cur_op   <= f_op;
      cur_addr <= f_addr;
      cur_data <= f_data;
      cur_mask <= f_mask;
    end
  end

  // Capture read data and count reads of this command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap      <= '0;
      poll_cnt <= '0;
    end else if (pop) begin
      poll_cnt <= '0;
    end else if (ack) begin
      cap      <= bus_rdata;
      poll_cnt <= poll_cnt + PW'(1);
    end
  end

  // Bus ack timeout counter, cleared outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_cnt <= '0;
    else if (state == S_ISSUE) tmo_cnt <= tmo_cnt + TW'(1);
    else                       tmo_cnt <= '0;
  end

  // Cycles spent waiting for irq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= '0;
    else if (pop)                wait_cnt <= '0;
    else if (state == S_WAITIRQ) wait_cnt <= wait_cnt + DATA_WIDTH'(1);
  end

  // Response payload, held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (rsp_ld) begin
      rsp_data <= rsp_d;
      rsp_err  <= rsp_e;
    end
  end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Directed bench for tpu_host_seq.
// Register-file slave model with poll and no-ack modes.
module tb_tpu_host_seq;
  import tpu_host_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        bus_sel;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        irq;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic        ack_en;
  int          poll_mode;
  int          poll_base;
  int          reads;
  int          wcycles;
  logic [31:0] mem [8];

  tpu_host_seq #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .CMD_DEPTH  (4),
    .POLL_MAX   (4),
    .BUS_TMO    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_mask  (cmd_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .bus_sel   (bus_sel),
    .bus_wen   (bus_wen),
    .bus_ren   (bus_ren),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .irq       (irq),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Slave: registered one-cycle ack, register file, counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ready <= 1'b0;
      reads     <= 0;
      wcycles   <= 0;
      for (int i = 0; i < 8; i++) mem[i] <= 32'h1000_0000 + i;
      mem[6] <= 32'h0001_0820;
    end else begin
      bus_ready <= ack_en && bus_sel && !bus_ready;
      if (bus_sel && bus_wen) wcycles <= wcycles + 1;
      if (bus_sel && bus_ren && bus_ready) reads <= reads + 1;
      if (bus_sel && bus_wen && bus_ready)
        mem[bus_addr[4:2]] <= bus_wdata;
    end
  end

  // Read data mux.
  always_comb begin
    bus_rdata = '0;
    if (bus_sel && bus_ren) begin
      if (poll_mode == 1)
        bus_rdata = (reads - poll_base >= 2) ? 32'h0000_0200
                                             : 32'h0000_0001;
      else if (poll_mode == 2)
        bus_rdata = 32'h0000_01FF;
      else
        bus_rdata = mem[bus_addr[4:2]];
    end
  end

  task automatic push(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] m);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL push_stall: cmd_ready=%0b want 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic e,
                         output int lat);
    lat = 0;
    d   = '0;
    e   = 1'b0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_timeout: rsp_valid=0 want 1");
    end else begin
      d = rsp_data;
      e = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v [10];
    logic [31:0] x [10];
    v = '{32'(cmd_ready), 32'(rsp_valid), 32'(busy), 32'(bus_sel),
          32'(bus_wen), 32'(bus_ren), bus_addr, bus_wdata,
          rsp_data, 32'(rsp_err)};
    x = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      total++;
      if (v[i] !== x[i]) begin
        bad++;
        $display("FAIL reset_out%0d: got %h want %h", i, v[i], x[i]);
      end
    end
  endtask

  task automatic test_write();
    logic [31:0] d; logic e; int lat; int w0;
    w0 = wcycles;
    push(OP_WRITE, TPU_REG_CFG, 32'h0008_0008, 0);
    get_rsp(d, e, lat);
    total++;
    if (wcycles - w0 !== 2) begin
      bad++; $display("FAIL write_pulse: got %0d want 2", wcycles - w0);
    end
    total++;
    if (d !== 32'h0 || e !== 1'b0) begin
      bad++; $display("FAIL write_rsp: got %h/%0b want 0/0", d, e);
    end
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL write_lat: got %0d want 4", lat);
    end
  endtask

  task automatic test_read();
    logic [31:0] d; logic e; int lat;
    push(OP_READ, TPU_REG_RESULT, 0, 0);
    get_rsp(d, e, lat);
    total++;
    if (d !== 32'h0001_0820 || e !== 1'b0) begin
      bad++; $display("FAIL read_rsp: got %h/%0b want 00010820/0", d, e);
    end
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL read_lat: got %0d want 4", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat;
    logic [31:0] exp_d [5];
    exp_d = '{32'd3, 32'h0008_0008, 32'h1000_0000, 32'h0, 32'hDEAD_BEEF};
    push(OP_WAIT_IRQ, 0, 0, 0);
    push(OP_READ, TPU_REG_CFG, 0, 0);
    push(OP_READ, TPU_REG_CTRL, 0, 0);
    push(OP_WRITE, TPU_REG_CMD, 32'hDEAD_BEEF, 0);
    push(OP_READ, TPU_REG_CMD, 0, 0);
    total++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL fifo_full: ready=%0b busy=%0b want 0/1",
               cmd_ready, busy);
    end
    irq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_rsp(d, e, lat);
      irq = 1'b0;
      total++;
      if (d !== exp_d[i] || e !== 1'b0) begin
        bad++;
        $display("FAIL b2b_rsp%0d: got %h/%0b want %h/0",
                 i, d, e, exp_d[i]);
      end
    end
  endtask

  task automatic test_poll();
    logic [31:0] d; logic e; int lat;
    poll_base = reads;
    poll_mode = 1;
    push(OP_POLL, TPU_REG_STATUS, 32'h200, 32'h200);
    get_rsp(d, e, lat);
    total++;
    if (reads - poll_base !== 3) begin
      bad++; $display("FAIL poll_reads: got %0d want 3", reads - poll_base);
    end
    total++;
    if (e !== 1'b0 || d[9] !== 1'b1) begin
      bad++; $display("FAIL poll_rsp: got %h/%0b want bit9=1/0", d, e);
    end
    poll_base = reads;
    poll_mode = 2;
    push(OP_POLL, TPU_REG_STATUS, 32'h200, 32'h200);
    get_rsp(d, e, lat);
    total++;
    if (reads - poll_base !== 4) begin
      bad++; $display("FAIL poll_max_reads: got %0d want 4",
                      reads - poll_base);
    end
    total++;
    if (e !== 1'b1 || d !== 32'h1FF) begin
      bad++; $display("FAIL poll_max_rsp: got %h/%0b want 1ff/1", d, e);
    end
    poll_mode = 0;
  endtask

  task automatic test_wait_irq();
    logic [31:0] d; logic e; int lat;
    push(OP_WAIT_IRQ, 0, 32'd100, 0);
    repeat (11) @(posedge clk);
    #1 irq = 1'b1;
    get_rsp(d, e, lat);
    irq = 1'b0;
    total++;
    if (d !== 32'd10 || e !== 1'b0) begin
      bad++; $display("FAIL wait_irq: got %0d/%0b want 10/0", d, e);
    end
    push(OP_WAIT_IRQ, 0, 32'd100, 0);
    get_rsp(d, e, lat);
    total++;
    if (e !== 1'b1 || lat !== 101) begin
      bad++; $display("FAIL wait_tmo: got err=%0b lat=%0d want 1/101",
                      e, lat);
    end
  endtask

  task automatic test_bus_timeout();
    logic [31:0] d; logic e; int lat;
    ack_en = 1'b0;
    push(OP_READ, TPU_REG_RESULT, 0, 0);
    get_rsp(d, e, lat);
    ack_en = 1'b1;
    total++;
    if (e !== 1'b1 || d !== 32'h0 || lat !== 17) begin
      bad++;
      $display("FAIL bus_tmo: got %h/%0b lat=%0d want 0/1 lat=17",
               d, e, lat);
    end
  endtask

  task automatic test_reset_mid();
    ack_en = 1'b0;
    push(OP_READ, TPU_REG_SRC, 0, 0);
    push(OP_WRITE, TPU_REG_DST, 32'h55, 0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus_sel !== 1'b1 || bus_ren !== 1'b1) begin
      bad++; $display("FAIL mid_issue: sel=%0b ren=%0b want 1/1",
                      bus_sel, bus_ren);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus_sel !== 1'b0 || bus_ren !== 1'b0 || busy !== 1'b0 ||
        cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: sel=%0b ren=%0b busy=%0b rdy=%0b",
               bus_sel, bus_ren, busy, cmd_ready);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || bus_sel !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: vld=%0b busy=%0b sel=%0b want 0/0/0",
               rsp_valid, busy, bus_sel);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_mask  = '0;
    rsp_ready = 1'b0;
    irq       = 1'b0;
    ack_en    = 1'b1;
    poll_mode = 0;
    poll_base = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_poll();
    test_wait_irq();
    test_bus_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
